// File: rtl/flash_arbiter.sv
// Round-robin arbiter and command sequencer sharing one mem_array flash block
// between four requesters; all outputs are registered.
module flash_arbiter #(
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [11:0] pid,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [7:0]  rdata,
    output logic [1:0]  err_code,
    output logic        active,
    output logic [7:0]  f_addr,
    output logic [7:0]  f_data_in,
    output logic [2:0]  f_pid,
    output logic        f_read_enable,
    output logic        f_write_enable,
    output logic        f_erase,
    input  logic [7:0]  f_data_out,
    input  logic        f_out_ready,
    input  logic        f_readwrite_valid,
    input  logic        f_erase_done,
    input  logic        f_error,
    input  logic        f_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FLASH   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_d;
    logic [1:0]  ptr, ptr_d;
    logic [1:0]  cmd_port, cmd_port_d;
    logic [1:0]  cmd_op, cmd_op_d;
    logic [7:0]  cnt, cnt_d;
    logic        illegal_pend, illegal_pend_d;

    logic [3:0]  gnt_d, done_d;
    logic [7:0]  rdata_d;
    logic [1:0]  err_code_d;
    logic        active_d;
    logic [7:0]  f_addr_d, f_data_in_d;
    logic [2:0]  f_pid_d;
    logic        f_read_enable_d, f_write_enable_d, f_erase_d;

    logic [1:0]  port_op   [4];
    logic [7:0]  port_addr [4];
    logic [7:0]  port_wdata[4];
    logic [2:0]  port_pid  [4];

    logic [1:0]  win;
    logic        op_complete;
    logic        flags_active;
    logic [7:0]  cnt_inc;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            port_op[i]    = op[2*i +: 2];
            port_addr[i]  = addr[8*i +: 8];
            port_wdata[i] = wdata[8*i +: 8];
            port_pid[i]   = pid[3*i +: 3];
        end
    end

    // Search starts just after the last port served so no requester can starve.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found = 1'b0;
        cand  = ptr;
        win   = ptr + 2'd1;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        op_complete = 1'b0;
        case (cmd_op)
            OP_READ:  op_complete = f_out_ready;
            OP_WRITE: op_complete = f_readwrite_valid;
            OP_ERASE: op_complete = f_erase_done;
            default:  op_complete = 1'b0;
        endcase
    end

    assign flags_active = f_out_ready | f_readwrite_valid | f_erase_done | f_error | f_busy;
    assign cnt_inc      = cnt + 8'd1;

    always_comb begin
        state_d          = state;
        ptr_d            = ptr;
        cmd_port_d       = cmd_port;
        cmd_op_d         = cmd_op;
        cnt_d            = cnt;
        illegal_pend_d   = illegal_pend;
        gnt_d            = 4'b0000;
        done_d           = 4'b0000;
        err_code_d       = ST_OK;
        rdata_d          = rdata;
        f_addr_d         = f_addr;
        f_data_in_d      = f_data_in;
        f_pid_d          = f_pid;
        f_read_enable_d  = f_read_enable;
        f_write_enable_d = f_write_enable;
        f_erase_d        = f_erase;

        case (state)
            IDLE: begin
                if (|req) begin
                    ptr_d      = win;
                    cmd_port_d = win;
                    cmd_op_d   = port_op[win];
                    gnt_d      = 4'b0001 << win;
                    cnt_d      = 8'd0;
                    // An illegal op never touches the flash; its done is issued from DRAIN.
                    if (port_op[win] == OP_ILLEGAL) begin
                        state_d        = DRAIN;
                        illegal_pend_d = 1'b1;
                    end else begin
                        state_d          = WAIT;
                        f_addr_d         = port_addr[win];
                        f_data_in_d      = port_wdata[win];
                        f_pid_d          = port_pid[win];
                        f_read_enable_d  = (port_op[win] == OP_READ);
                        f_write_enable_d = (port_op[win] == OP_WRITE);
                        f_erase_d        = (port_op[win] == OP_ERASE);
                    end
                end
            end

            WAIT: begin
                if (f_error || op_complete || (cnt_inc == TIMEOUT_CNT)) begin
                    state_d          = DRAIN;
                    cnt_d            = 8'd0;
                    f_read_enable_d  = 1'b0;
                    f_write_enable_d = 1'b0;
                    f_erase_d        = 1'b0;
                    done_d           = 4'b0001 << cmd_port;
                    if (f_error) begin
                        err_code_d = ST_FLASH;
                    end else if (op_complete) begin
                        err_code_d = ST_OK;
                        if (cmd_op == OP_READ) begin
                            rdata_d = f_data_out;
                        end
                    end else begin
                        err_code_d = ST_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            DRAIN: begin
                if (illegal_pend) begin
                    done_d         = 4'b0001 << cmd_port;
                    err_code_d     = ST_ILLEGAL;
                    illegal_pend_d = 1'b0;
                end
                // Stale flags from the last command must clear before the next issue.
                if (!flags_active) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= 2'd3;
            cmd_port       <= 2'd0;
            cmd_op         <= 2'd0;
            cnt            <= 8'd0;
            illegal_pend   <= 1'b0;
            gnt            <= 4'b0000;
            done           <= 4'b0000;
            rdata          <= 8'd0;
            err_code       <= 2'b00;
            active         <= 1'b0;
            f_addr         <= 8'd0;
            f_data_in      <= 8'd0;
            f_pid          <= 3'd0;
            f_read_enable  <= 1'b0;
            f_write_enable <= 1'b0;
            f_erase        <= 1'b0;
        end else begin
            state          <= state_d;
            ptr            <= ptr_d;
            cmd_port       <= cmd_port_d;
            cmd_op         <= cmd_op_d;
            cnt            <= cnt_d;
            illegal_pend   <= illegal_pend_d;
            gnt            <= gnt_d;
            done           <= done_d;
            rdata          <= rdata_d;
            err_code       <= err_code_d;
            active         <= active_d;
            f_addr         <= f_addr_d;
            f_data_in      <= f_data_in_d;
            f_pid          <= f_pid_d;
            f_read_enable  <= f_read_enable_d;
            f_write_enable <= f_write_enable_d;
            f_erase        <= f_erase_d;
        end
    end

endmodule
